// File: rtl/sat_pkg.sv
// Constants and types shared by the clause arbiter, the clause queues and the BCP engines.
package sat_pkg;

  localparam int OUTPUT_CNT      = 4;
  localparam int CLAUSE_WIDTH    = 4;
  localparam int ELEMENT_CNT     = 1024;
  localparam int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1;

  typedef logic [ELEMENT_BIT_CNT-1:0] literal_t;
  typedef literal_t [CLAUSE_WIDTH-1:0] clause_t;

endpackage

// File: rtl/clause_queue.sv
// Per-engine first-word-fall-through clause FIFO fed by one lane of the clause arbiter.
// Handshakes: upstream transfers when clause_valid_in & grant_in & ~full_out; downstream
// transfers when clause_valid_out & clause_ready_in. Both are sampled on the rising edge.
module clause_queue #(
  parameter int DEPTH           = 8,
  parameter int CLAUSE_WIDTH    = sat_pkg::CLAUSE_WIDTH,
  parameter int ELEMENT_BIT_CNT = sat_pkg::ELEMENT_BIT_CNT
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_in,
  input  logic                                    clause_valid_in,
  input  logic                                    grant_in,
  output logic                                    full_out,
  output logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_out,
  output logic                                    clause_valid_out,
  input  logic                                    clause_ready_in,
  input  logic                                    flush_in,
  output logic [$clog2(DEPTH):0]                  count_out,
  output logic                                    overflow_err
);

  localparam int W     = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // full_out depends only on registered count so the arbiter's combinational
  // grant cannot form a loop through this queue.
  assign full_out         = (count == FULL_CNT);
  assign clause_valid_out = (count != '0);
  assign clause_out       = clause_valid_out ? mem[rd_ptr] : '0;
  assign count_out        = count;

  assign push = clause_valid_in & grant_in & ~full_out;
  assign pop  = clause_valid_out & clause_ready_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
      // Sticky until reset; a flush does not clear the record of a dropped clause.
      if (clause_valid_in && grant_in && full_out) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush_in) mem[wr_ptr] <= clause_in;
  end

endmodule
